// File: rtl/alu_issue.sv
// Command-issue front end for a 4-bit combinational ALU: an in-order command FIFO
// feeding the ALU and a valid/ready result register that captures its outputs.
module alu_issue #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [2:0] alu_fnselec,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_res,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  input  logic       alu_carry,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [2:0] res_flags,
  output logic [2:0] res_op,
  output logic [2:0] fifo_count,
  output logic [7:0] op_count
);

  // Occupancy is reported on a 3-bit port, so DEPTH is limited to 2 or 4.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [2:0]    count;
  logic          push;
  logic          pop;
  logic          consume;

  // Ready is held low during reset and never looks through a same-cycle pop.
  assign cmd_ready  = (count < 3'(DEPTH)) && rst_n;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (count != 3'd0) && (!res_valid || res_ready);
  assign consume    = res_valid && res_ready;
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  assign {alu_fnselec, alu_a, alu_b} = (count != 3'd0) ? head : '0;

  // NOTE: command storage has no reset; count and pointers alone decide which
  // entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
      res_op    <= '0;
    end else if (pop) begin
      res_valid <= 1'b1;
      res_data  <= alu_res;
      res_flags <= {alu_carry, alu_overflow, alu_zero};
      res_op    <= head.op;
    end else if (consume) begin
      res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       op_count <= '0;
    else if (consume) op_count <= op_count + 8'd1;
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: a local 4-bit ALU model, a hand-computed vector
// table, and sequences for back-pressure, drain, reset and pointer wrap.
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic [2:0] alu_fnselec;
  logic [3:0] alu_a, alu_b, alu_res;
  logic       alu_zero, alu_overflow, alu_carry;
  logic       res_valid, res_ready;
  logic [3:0] res_data;
  logic [2:0] res_flags, res_op, fifo_count;
  logic [7:0] op_count;

  int total = 0;
  int bad   = 0;

  alu_issue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_fnselec(alu_fnselec), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags), .res_op(res_op),
    .fifo_count(fifo_count), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not a,
  // 110 unsigned a<b, 111 a==b. Returns {carry, overflow, zero, res}.
  function automatic logic [6:0] alu_model(input logic [2:0] op,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'b001: begin
        s = {1'b0, a} + {1'b0, ~b} + 5'd1;
        r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = ~a;
      3'b110:  r = (a < b)  ? 4'd1 : 4'd0;
      default: r = (a == b) ? 4'd1 : 4'd0;
    endcase
    return {c, v, (r == 4'd0), r};
  endfunction

  always_comb {alu_carry, alu_overflow, alu_zero, alu_res} = alu_model(alu_fnselec, alu_a, alu_b);

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_data;
    logic [2:0] exp_flags;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " res_valid"},  32'(res_valid), 0);
    check({tag, " res_data"},   32'(res_data), 0);
    check({tag, " res_flags"},  32'(res_flags), 0);
    check({tag, " res_op"},     32'(res_op), 0);
    check({tag, " fifo_count"}, 32'(fifo_count), 0);
    check({tag, " op_count"},   32'(op_count), 0);
    check({tag, " cmd_ready"},  32'(cmd_ready), 0);
    check({tag, " alu_drive"},  32'({alu_fnselec, alu_a, alu_b}), 0);
  endtask

  logic [9:0] sb_q[$];
  logic [9:0] exp_r;
  int         n;
  logic       was_ready;

  initial begin
    // Hand-computed vectors: {op, a, b, res_data, {carry, overflow, zero}}
    vecs[0]  = '{3'b000, 4'd7,  4'd9,  4'd0,  3'b101};  // 16 wraps, carry, zero
    vecs[1]  = '{3'b000, 4'd7,  4'd1,  4'd8,  3'b010};  // signed overflow
    vecs[2]  = '{3'b001, 4'd3,  4'd5,  4'hE,  3'b000};  // borrow: no carry-out
    vecs[3]  = '{3'b001, 4'd5,  4'd5,  4'd0,  3'b101};
    vecs[4]  = '{3'b010, 4'hC,  4'hA,  4'd8,  3'b000};
    vecs[5]  = '{3'b011, 4'd0,  4'd0,  4'd0,  3'b001};
    vecs[6]  = '{3'b100, 4'hF,  4'hF,  4'd0,  3'b001};
    vecs[7]  = '{3'b101, 4'd5,  4'd0,  4'hA,  3'b000};
    vecs[8]  = '{3'b111, 4'd5,  4'd5,  4'd1,  3'b000};
    vecs[9]  = '{3'b110, 4'd9,  4'd3,  4'd0,  3'b001};
    vecs[10] = '{3'b110, 4'd3,  4'd9,  4'd1,  3'b000};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b1;
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Table: one command at a time, push at edge N, result visible after N+1.
    for (int i = 0; i < 11; i++) begin
      cmd_valid = 1'b1; cmd_op = vecs[i].op; cmd_a = vecs[i].a; cmd_b = vecs[i].b;
      tick();
      cmd_valid = 1'b0;
      check($sformatf("v%0d count_after_push", i), 32'(fifo_count), 1);
      check($sformatf("v%0d alu_drive", i), 32'({alu_fnselec, alu_a, alu_b}),
            32'({vecs[i].op, vecs[i].a, vecs[i].b}));
      check($sformatf("v%0d valid_early", i), 32'(res_valid), 0);
      tick();
      check($sformatf("v%0d res_valid", i), 32'(res_valid), 1);
      check($sformatf("v%0d res_data", i), 32'(res_data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d res_flags", i), 32'(res_flags), 32'(vecs[i].exp_flags));
      check($sformatf("v%0d res_op", i), 32'(res_op), 32'(vecs[i].op));
      check($sformatf("v%0d alu_idle", i), 32'({alu_fnselec, alu_a, alu_b}), 0);
      tick();
      check($sformatf("v%0d valid_cleared", i), 32'(res_valid), 0);
      check($sformatf("v%0d op_count", i), 32'(op_count), 32'(i + 1));
    end

    // Back-pressure: cmd_valid held high, nothing consumed.
    res_ready = 1'b0;
    cmd_valid = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      cmd_op = vecs[n].op; cmd_a = vecs[n].a; cmd_b = vecs[n].b;
      was_ready = cmd_ready;
      tick();
      if (was_ready) n++;
    end
    check("bp accepted", 32'(n), 5);
    check("bp cmd_ready", 32'(cmd_ready), 0);
    check("bp fifo_count", 32'(fifo_count), 4);
    check("bp res_valid", 32'(res_valid), 1);
    check("bp res_data held", 32'(res_data), 32'(vecs[0].exp_data));

    // Drain in push order, one per cycle; ready returns after the first pop.
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("drain%0d res_valid", k), 32'(res_valid), 1);
      check($sformatf("drain%0d res_data", k), 32'(res_data), 32'(vecs[k].exp_data));
      check($sformatf("drain%0d res_op", k), 32'(res_op), 32'(vecs[k].op));
      check($sformatf("drain%0d res_flags", k), 32'(res_flags), 32'(vecs[k].exp_flags));
      check($sformatf("drain%0d cmd_ready", k), 32'(cmd_ready), (k == 0) ? 0 : 1);
      tick();
    end
    check("drain empty valid", 32'(res_valid), 0);
    check("drain empty count", 32'(fifo_count), 0);
    check("drain op_count", 32'(op_count), 16);

    // Mid-operation reset: 3 queued plus one held result.
    res_ready = 1'b0;
    for (int k = 5; k < 9; k++) begin
      cmd_valid = 1'b1; cmd_op = vecs[k].op; cmd_a = vecs[k].a; cmd_b = vecs[k].b;
      tick();
    end
    cmd_valid = 1'b0;
    check("pre-rst fifo_count", 32'(fifo_count), 3);
    check("pre-rst res_valid", 32'(res_valid), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("post-rst%0d res_valid", k), 32'(res_valid), 0);
      check($sformatf("post-rst%0d fifo_count", k), 32'(fifo_count), 0);
    end

    // Streaming 300 commands with a scoreboard; occupancy steady at 1.
    for (int i = 0; i < 300; i++) begin
      if (i >= 1) check($sformatf("stream%0d fifo_count", i), 32'(fifo_count), 1);
      if (res_valid) begin
        exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : 10'h3FF;
        check($sformatf("stream%0d result", i), 32'({res_op, res_flags, res_data}), 32'(exp_r));
      end
      cmd_valid = 1'b1;
      cmd_op = 3'($urandom_range(0, 7));
      cmd_a  = 4'($urandom_range(0, 15));
      cmd_b  = 4'($urandom_range(0, 15));
      sb_q.push_back({cmd_op, alu_model(cmd_op, cmd_a, cmd_b)});
      tick();
    end
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (res_valid) begin
        exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : 10'h3FF;
        check("stream tail result", 32'({res_op, res_flags, res_data}), 32'(exp_r));
      end
      tick();
    end
    check("stream all results seen", 32'(sb_q.size()), 0);
    check("stream op_count wrap", 32'(op_count), 44);
    check("stream final valid", 32'(res_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
